// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Holds the chunk-width derivation, mode encoding, and the signed clamp limits used by saturation.
package adder_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_of(input int w, input int stages);
        return w / stages;
    endfunction

    // Limits are produced 64 bits wide; callers slice them down to W.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple-carry segment built from 1-bit full adders.
// One instance per pipeline stage; the carry-out feeds the next stage's register.
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[N];

endmodule

// File: rtl/adder_pipe_rca.sv
// Pipelined W-bit ripple-carry adder/subtractor, one CHUNK-bit segment per stage, valid/ready stream.
// Define ADDER_PIPE_SAT_EN to add the per-beat 'sat' input that clamps overflowing results.
module adder_pipe_rca
    import adder_pipe_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
`ifdef ADDER_PIPE_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         ovf
);

    localparam int CHUNK = chunk_of(W, STAGES);
    localparam int L     = STAGES - 1;

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [63:0]  SMAX_64 = sat_max(W);
    localparam logic [63:0]  SMIN_64 = sat_min(W);
    localparam logic [W-1:0] SMAX    = SMAX_64[W-1:0];
    localparam logic [W-1:0] SMIN    = SMIN_64[W-1:0];
`endif

    logic stall;
    logic fire;

    // Stage k registers: a_q/b_q carry the operand (upper chunks still pending),
    // s_q the completed low chunks, c_q the chunk carry-out.
    logic [STAGES:1]             vld_pipe;
    logic [STAGES-1:0][W-1:0]    a_q, b_q, s_q;
    logic [STAGES-1:0]           c_q, sat_q;
    logic                        ovf_q;

    logic [STAGES-1:0][W-1:0]    a_i, b_i, s_i, s_nx;
    logic [STAGES-1:0]           c_i, sat_i, v_i;
    logic [STAGES-1:0][CHUNK-1:0] ch_s;
    logic [STAGES-1:0]           ch_c;
    logic                        ovf_nx;
    logic [W-1:0]                sum_nx;

    assign stall    = vld_pipe[STAGES] & ~out_ready;
    assign in_ready = ~stall;
    assign fire     = in_valid & in_ready;

    // Stage inputs: stage 0 sees the ports, later stages see the previous stage registers.
    always_comb begin
        a_i[0] = a;
        b_i[0] = (sub == OP_ADD) ? b : ~b;
        c_i[0] = (sub == OP_SUB) ? 1'b1 : cin;
        s_i[0] = '0;
        v_i[0] = fire;
`ifdef ADDER_PIPE_SAT_EN
        sat_i[0] = sat;
`else
        sat_i[0] = 1'b0;
`endif
        for (int k = 1; k < STAGES; k++) begin
            a_i[k]   = a_q[k-1];
            b_i[k]   = b_q[k-1];
            c_i[k]   = c_q[k-1];
            s_i[k]   = s_q[k-1];
            v_i[k]   = vld_pipe[k];
            sat_i[k] = sat_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(.N(CHUNK)) u_chunk (
            .a  (a_i[k][k*CHUNK +: CHUNK]),
            .b  (b_i[k][k*CHUNK +: CHUNK]),
            .ci (c_i[k]),
            .s  (ch_s[k]),
            .co (ch_c[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_i[k];
            s_nx[k][k*CHUNK +: CHUNK] = ch_s[k];
        end
    end

    // Overflow and optional clamp are resolved as the final chunk completes.
    always_comb begin
        ovf_nx = (a_i[L][W-1] == b_i[L][W-1]) & (s_nx[L][W-1] != a_i[L][W-1]);
        sum_nx = s_nx[L];
`ifdef ADDER_PIPE_SAT_EN
        if (sat_i[L] && ovf_nx)
            sum_nx = a_i[L][W-1] ? SMIN : SMAX;
`endif
    end

    // Data registers load only on a valid beat so outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            sat_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (!stall) begin
            vld_pipe[1] <= fire;
            for (int k = 1; k < STAGES; k++)
                vld_pipe[k+1] <= vld_pipe[k];
            for (int k = 0; k < STAGES; k++) begin
                if (v_i[k]) begin
                    a_q[k]   <= a_i[k];
                    b_q[k]   <= b_i[k];
                    c_q[k]   <= ch_c[k];
                    sat_q[k] <= sat_i[k];
                    s_q[k]   <= (k == L) ? sum_nx : s_nx[k];
                end
            end
            if (v_i[L])
                ovf_q <= ovf_nx;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = s_q[L];
    assign carry     = c_q[L];
    assign ovf       = ovf_q;

    // Last-stage operand copies and already-consumed operand chunks have no reader.
    logic unused_bits;
    assign unused_bits = ^{a_q[L], b_q[L], sat_q[L], a_i, b_i, sat_i};

endmodule
